vector_unpack: RTL and testbench

VECTOR_UNPACK -- requirements
Module: vector_unpack

---
 rtl/vector_unpack.sv | 50 +++++
 tb/tb_vector_unpack.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vector_unpack.sv
// vector_unpack: 5-bit word to 3-bit symbol unpacker, MSB-first.
// Optional residue flush with zero padding under VECTOR_UNPACK_FLUSH_EN.
module vector_unpack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef VECTOR_UNPACK_FLUSH_EN
  input  logic       flush,
  output logic       out_pad,
`endif
  output logic [3:0] fill
);
  logic [7:0] sbuf, sbuf_n, sh;
  logic [3:0] cnt, cnt_n, cnt_sh;
  logic       pad, in_x, out_x;
`ifdef VECTOR_UNPACK_FLUSH_EN
  assign pad      = flush && (cnt == 4'd1 || cnt == 4'd2);
  assign out_pad  = pad;
  assign in_ready = cnt <= 4'd3 && !flush;
`else
  assign pad      = 1'b0;
  assign in_ready = cnt <= 4'd3;
`endif
  assign out_valid = cnt >= 4'd3 || pad;
  assign out_data  = sbuf[7:5];
  assign fill      = cnt;
  // Output shift is applied before the append so a word lands right behind the surviving bits.
  always_comb begin
    out_x  = out_valid && out_ready;
    in_x   = in_valid && in_ready;
    sh     = out_x ? (pad ? 8'd0 : sbuf << 3) : sbuf;
    cnt_sh = out_x ? (pad ? 4'd0 : cnt - 4'd3) : cnt;
    sbuf_n = in_x ? sh | ({in_data, 3'b000} >> cnt_sh) : sh;
    cnt_n  = in_x ? cnt_sh + 4'd5 : cnt_sh;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf <= 8'd0;
      cnt  <= 4'd0;
    end else begin
      sbuf <= sbuf_n;
      cnt  <= cnt_n;
    end
  end
endmodule

// File: tb/tb_vector_unpack.sv
// tb_vector_unpack: directed table, corner sequences and random queue-model check for vector_unpack.
module tb_vector_unpack;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] in_data = 5'd0;
  logic       in_ready, out_valid;
  logic [2:0] out_data;
  logic [3:0] fill;
`ifdef VECTOR_UNPACK_FLUSH_EN
  logic       flush = 1'b0;
  logic       out_pad;
`endif
  int n_tests = 0, n_fail = 0;

  vector_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef VECTOR_UNPACK_FLUSH_EN
    .flush(flush), .out_pad(out_pad),
`endif
    .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [4:0] d;
    logic       ordy;
    logic [3:0] f;
    logic       rdy;
    logic       vld;
    logic [2:0] od;
  } vec_t;
  vec_t tbl[6];

  bit         q[$], ib[$], ob[$];
  logic [4:0] words[30];
  int         w, pre, bad;

  initial begin
    // words 10110, 01101 with sink always ready: 101, 100, 110, residue of one bit
    tbl[0] = '{1'b1, 5'b10110, 1'b1, 4'd0, 1'b1, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 5'b01101, 1'b1, 4'd5, 1'b0, 1'b1, 3'b101};
    tbl[2] = '{1'b1, 5'b01101, 1'b1, 4'd2, 1'b1, 1'b0, 3'b000};
    tbl[3] = '{1'b0, 5'b00000, 1'b1, 4'd7, 1'b0, 1'b1, 3'b100};
    tbl[4] = '{1'b0, 5'b00000, 1'b1, 4'd4, 1'b0, 1'b1, 3'b110};
    tbl[5] = '{1'b0, 5'b00000, 1'b1, 4'd1, 1'b1, 1'b0, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_fill", fill, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
`ifdef VECTOR_UNPACK_FLUSH_EN
    chk("rst_pad", out_pad, 0);
`endif
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].f);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].od);
      step();
    end

`ifdef VECTOR_UNPACK_FLUSH_EN
    flush = 1'b1;
    #1;
    chk("flush_valid", out_valid, 1);
    chk("flush_data", out_data, 3'b100);
    chk("flush_pad", out_pad, 1);
    chk("flush_ready", in_ready, 0);
    step();
    chk("flush_fill", fill, 0);
    chk("flush_valid_after", out_valid, 0);
    chk("flush_pad_after", out_pad, 0);
    flush = 1'b0;
`else
    repeat (3) step();
    chk("residue_fill", fill, 1);
    chk("residue_valid", out_valid, 0);
`endif

    // stall: one word accepted, symbol held while the sink refuses
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 5'b11111;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_fill", fill, 5);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 3'b111);
      step();
    end

    // asynchronous reset mid-stream at fill=5
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_fill", fill, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_data", out_data, 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 5'b00111;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 3'b001);
    chk("post_rst_fill", fill, 5);

    // random stream against a bit-queue model
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    q.delete();
    ib.delete();
    ob.delete();
    for (int i = 0; i < 30; i++) begin
      words[i] = 5'($urandom);
      for (int b = 4; b >= 0; b--) ib.push_back(words[i][b]);
    end
    w = 0;
    for (int cyc = 0; cyc < 3000 && !(w == 30 && q.size() == 0); cyc++) begin
      in_valid = (w < 30) && ($urandom_range(0, 3) != 0);
      in_data = in_valid ? words[w] : 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      pre = q.size();
      chk("rnd_fill", fill, 8'(pre));
      chk("rnd_ready", in_ready, pre <= 3);
      chk("rnd_valid", out_valid, pre >= 3);
      if (pre >= 3) chk("rnd_data", out_data, {5'd0, q[0], q[1], q[2]});
      if (out_valid && out_ready) begin
        ob.push_back(out_data[2]);
        ob.push_back(out_data[1]);
        ob.push_back(out_data[0]);
      end
      if (pre >= 3 && out_ready) repeat (3) void'(q.pop_front());
      if (in_valid && pre <= 3) begin
        for (int b = 4; b >= 0; b--) q.push_back(words[w][b]);
        w++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("rnd_drained", (w == 30 && q.size() == 0), 1);
    chk("rnd_out_len", ob.size() == 150, 1);
    bad = 0;
    for (int i = 0; i < 150 && i < ob.size(); i++) if (ob[i] != ib[i]) bad++;
    chk("rnd_stream_errs", 8'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
